// File: rtl/rv32i_pkg.sv
// Shared RV32I types: ALU operation encoding from the decoder and shift-amount width.
package rv32i_pkg;

   localparam int SHAMT_W = 5;

   typedef enum logic [3:0] {
      ADD_OP = 4'd0,
      SUB_OP = 4'd1,
      AND_OP = 4'd2,
      OR_OP  = 4'd3,
      XOR_OP = 4'd4,
      SLL_OP = 4'd5,
      SRL_OP = 4'd6,
      SRA_OP = 4'd7,
      BEQ_OP = 4'd8
   } alu_op_t;

   function automatic logic isShiftOp(input alu_op_t op);
      return (op == SLL_OP) || (op == SRL_OP) || (op == SRA_OP);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add/sub/logic/compare, plus a barrel shifter when
// ALU_FAST_SHIFT_EN is defined. Unknown encodings behave as ADD.
module alu_comb
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_op_t          op_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   output logic [XLEN-1:0]  result_o,
   output logic             zero_o
);

`ifdef ALU_FAST_SHIFT_EN
   localparam int ShW = $clog2(XLEN);
   logic [ShW-1:0] shamt;
   assign shamt = b_i[ShW-1:0];
`endif

   always_comb begin
      result_o = a_i + b_i;
      case (op_i)
         SUB_OP:  result_o = a_i - b_i;
         AND_OP:  result_o = a_i & b_i;
         OR_OP:   result_o = a_i | b_i;
         XOR_OP:  result_o = a_i ^ b_i;
         BEQ_OP:  result_o = '0;
`ifdef ALU_FAST_SHIFT_EN
         SLL_OP:  result_o = a_i << shamt;
         SRL_OP:  result_o = a_i >> shamt;
         SRA_OP:  result_o = $signed(a_i) >>> shamt;
`endif
         default: result_o = a_i + b_i;
      endcase
      // Branch compare reports operand equality; everything else reports a zero result.
      zero_o = (op_i == BEQ_OP) ? (a_i == b_i) : (result_o == '0);
   end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle RV32I execute unit with valid/ready handshakes and a serial shifter.
// Define ALU_FAST_SHIFT_EN to replace the serial shifter with a one-cycle barrel shift.
module alu_seq_exec
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  alu_op_t          alu_ctrl,
   input  logic [XLEN-1:0]  src_a,
   input  logic [XLEN-1:0]  src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic             zero
);

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t           state_q;
   logic             inReady_q;
   logic             outValid_q;
   logic             zero_q;
   logic [XLEN-1:0]  result_q;
   logic [XLEN-1:0]  combResult;
   logic             combZero;

   alu_comb #(.XLEN(XLEN)) uComb (
      .op_i     (alu_ctrl),
      .a_i      (src_a),
      .b_i      (src_b),
      .result_o (combResult),
      .zero_o   (combZero)
   );

`ifndef ALU_FAST_SHIFT_EN
   localparam int ShW = $clog2(XLEN);
   localparam logic [ShW-1:0] CntOne = ShW'(1);

   alu_op_t          shiftOp_q;
   logic [ShW-1:0]   cnt_q;
   logic [ShW-1:0]   shamt_d;
   logic [XLEN-1:0]  shiftStep_d;

   assign shamt_d = src_b[ShW-1:0];

   // The result register doubles as the shift register while iterating.
   always_comb begin
      shiftStep_d = result_q >> 1;
      if (shiftOp_q == SLL_OP)
         shiftStep_d = result_q << 1;
      else if (shiftOp_q == SRA_OP)
         shiftStep_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
         shiftOp_q  <= ADD_OP;
         cnt_q      <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  inReady_q  <= 1'b0;
                  state_q    <= DONE;
                  outValid_q <= 1'b1;
                  result_q   <= combResult;
                  zero_q     <= combZero;
`ifndef ALU_FAST_SHIFT_EN
                  if (isShiftOp(alu_ctrl)) begin
                     shiftOp_q <= alu_ctrl;
                     cnt_q     <= shamt_d;
                     result_q  <= src_a;
                     zero_q    <= (src_a == '0);
                     if (shamt_d != '0) begin
                        state_q    <= SHIFT;
                        outValid_q <= 1'b0;
                     end
                  end
`endif
               end
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
               result_q <= shiftStep_d;
               cnt_q    <= cnt_q - CntOne;
               if (cnt_q == CntOne) begin
                  state_q    <= DONE;
                  outValid_q <= 1'b1;
                  zero_q     <= (shiftStep_d == '0);
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  state_q    <= IDLE;
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign result    = result_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed vector table, handshake/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq_exec;
   import rv32i_pkg::*;

   logic          clk = 1'b0;
   logic          rstN;
   logic          inValid;
   logic          inReady;
   alu_op_t       aluCtrl;
   logic [31:0]   srcA;
   logic [31:0]   srcB;
   logic          outValid;
   logic          outReady;
   logic [31:0]   result;
   logic          zero;

   int checks = 0;
   int errors = 0;

   alu_seq_exec #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .alu_ctrl  (aluCtrl),
      .src_a     (srcA),
      .src_b     (srcB),
      .out_valid (outValid),
      .out_ready (outReady),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expResult;
      logic        expZero;
      int          expLat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        z;
      int          lat;
   } exp_t;

   // Reference behaviour straight from the operation rules.
   function automatic exp_t refModel(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int sh;
      sh = int'(b % 32);
      e.lat = 1;
      case (op)
         SUB_OP: e.res = a - b;
         AND_OP: e.res = a & b;
         OR_OP:  e.res = a | b;
         XOR_OP: e.res = a ^ b;
         SLL_OP: e.res = a << sh;
         SRL_OP: e.res = a >> sh;
         SRA_OP: e.res = 32'($signed(a) >>> sh);
         BEQ_OP: e.res = 32'd0;
         default: e.res = a + b;
      endcase
      e.z = (op == BEQ_OP) ? (a == b) : (e.res == 32'd0);
`ifndef ALU_FAST_SHIFT_EN
      if ((op == SLL_OP || op == SRL_OP || op == SRA_OP) && sh > 0)
         e.lat = sh + 1;
`endif
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Issue one request at a negedge and return the number of edges until out_valid.
   task automatic applyStimulus(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, output int lat);
      int guard;
      guard = 0;
      while (!inReady && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!inReady) checkOutput("in_ready_wait", 32'(inReady), 32'd1);
      aluCtrl = op;
      srcA    = a;
      srcB    = b;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      lat = 1;
      while (!outValid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
   endtask

   vec_t vecs[15];

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int expLat;
      exp_t e;
      alu_op_t op;
      logic [31:0] a;
      logic [31:0] b;

      vecs[0]  = '{"add_5_7",      ADD_OP, 32'd5,        32'd7,        32'd12,       1'b0, 1};
      vecs[1]  = '{"sub_eq",       SUB_OP, 32'd9,        32'd9,        32'd0,        1'b1, 1};
      vecs[2]  = '{"beq_equal",    BEQ_OP, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0,        1'b1, 1};
      vecs[3]  = '{"beq_differ",   BEQ_OP, 32'hDEADBEEF, 32'hDEADBEEE, 32'd0,        1'b0, 1};
      vecs[4]  = '{"sra_4",        SRA_OP, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 5};
      vecs[5]  = '{"srl_4",        SRL_OP, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 5};
      vecs[6]  = '{"sll_b37",      SLL_OP, 32'd1,        32'd37,       32'h00000020, 1'b0, 6};
      vecs[7]  = '{"sll_0",        SLL_OP, 32'h00001234, 32'd0,        32'h00001234, 1'b0, 1};
      vecs[8]  = '{"xor_self",     XOR_OP, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd0,        1'b1, 1};
      vecs[9]  = '{"or",           OR_OP,  32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1'b0, 1};
      vecs[10] = '{"and",          AND_OP, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1};
      vecs[11] = '{"sra_31_pos",   SRA_OP, 32'h7FFFFFFF, 32'd31,       32'd0,        1'b1, 32};
      vecs[12] = '{"srl_31",       SRL_OP, 32'hFFFFFFFF, 32'd31,       32'd1,        1'b0, 32};
      vecs[13] = '{"illegal_add",  alu_op_t'(4'hF), 32'hFFFFFFFF, 32'd1, 32'd0,      1'b1, 1};
      vecs[14] = '{"sub_wrap",     SUB_OP, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1};

      rstN     = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      aluCtrl  = ADD_OP;
      srcA     = '0;
      srcB     = '0;
      repeat (3) @(negedge clk);

      checkOutput("reset_in_ready",  32'(inReady),  32'd1);
      checkOutput("reset_out_valid", 32'(outValid), 32'd0);
      checkOutput("reset_result",    result,        32'd0);
      checkOutput("reset_zero",      32'(zero),     32'd0);
      rstN = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
`ifdef ALU_FAST_SHIFT_EN
         expLat = 1;
`else
         expLat = vecs[i].expLat;
`endif
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         checkOutput({vecs[i].name, "_result"},  result,     vecs[i].expResult);
         checkOutput({vecs[i].name, "_zero"},    32'(zero),  32'(vecs[i].expZero));
         checkOutput({vecs[i].name, "_latency"}, 32'(lat),   32'(expLat));
         @(negedge clk);
         checkOutput({vecs[i].name, "_in_ready_after"}, 32'(inReady), 32'd1);
      end

      // Backpressure: result held, no new request accepted while DONE.
      outReady = 1'b0;
      applyStimulus(ADD_OP, 32'd3, 32'd4, lat);
      checkOutput("bp_first_result", result, 32'd7);
      for (int k = 0; k < 3; k++) begin
         aluCtrl = SUB_OP;
         srcA    = 32'd100;
         srcB    = 32'd1;
         inValid = 1'b1;
         @(negedge clk);
         checkOutput("bp_result_stable", result,          32'd7);
         checkOutput("bp_zero_stable",   32'(zero),       32'd0);
         checkOutput("bp_out_valid",     32'(outValid),   32'd1);
         checkOutput("bp_in_ready_low",  32'(inReady),    32'd0);
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_in_ready",  32'(inReady),  32'd1);
      checkOutput("bp_release_out_valid", 32'(outValid), 32'd0);
      @(negedge clk);
      checkOutput("bp_ignored_req", 32'(outValid), 32'd0);

      // Reset in the middle of a long shift.
      aluCtrl = SLL_OP;
      srcA    = 32'd1;
      srcB    = 32'd20;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      checkOutput("midrst_result",    result,        32'd0);
      checkOutput("midrst_in_ready",  32'(inReady),  32'd1);
      rstN = 1'b1;
      applyStimulus(ADD_OP, 32'd1, 32'd1, lat);
      checkOutput("postrst_add", result,   32'd2);
      checkOutput("postrst_lat", 32'(lat), 32'd1);
      @(negedge clk);

      // Randomized ops, including undefined encodings and equal operands.
      for (int n = 0; n < 60; n++) begin
         op = alu_op_t'(4'($urandom_range(0, 15)));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? a : 32'($urandom);
         e  = refModel(op, a, b);
         applyStimulus(op, a, b, lat);
         checkOutput($sformatf("rand%0d_op%0d_result", n, op), result,    e.res);
         checkOutput($sformatf("rand%0d_op%0d_zero", n, op),   32'(zero), 32'(e.z));
         checkOutput($sformatf("rand%0d_op%0d_lat", n, op),    32'(lat),  32'(e.lat));
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

- Multi-cycle RV32I execute unit. Consumes the `alu_op_t` control produced by the ALU decoder plus two operands, and returns a result and zero flag over valid/ready handshakes.
- Add/sub/logic/compare complete in one cycle. Shifts iterate one bit position per cycle.
- Sits between decode/operand-select and writeback/branch logic in the multi-cycle core.

## Interface

- `XLEN`, 32, operand/result width; shift amount field is `$clog2(XLEN)` bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operation request valid.
- `in_ready`  out  1  block can accept a request.
- `alu_ctrl`  in  `alu_op_t`  operation from ALU decoder.
- `src_a`  in  XLEN  operand A.
- `src_b`  in  XLEN  operand B; low `$clog2(XLEN)` bits are the shift amount for shifts.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  XLEN  operation result.
- `zero`  out  1  result==0; for `BEQ_OP`, src_a==src_b.

## Operation

- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture op and operands.
  - Non-shift op: compute the result into the result register and go to DONE.
  - Shift with shamt==0: result=src_a, go to DONE.
  - Shift with shamt>0: load the shift register with src_a and the counter with shamt, go to SHIFT.
- **SHIFT**
  - Each cycle: shift by 1 (SLL left with zero fill; SRL right with zero fill; SRA right with sign fill) and decrement the counter.
  - When the counter reaches 0 after the step, go to DONE.
  - `in_ready`=0.
- **DONE**
  - `out_valid`=1; `result`/`zero` held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0; no overlap between issuing and draining.
- **Op results**
  - ADD: a+b modulo 2^XLEN.
  - SUB: a−b modulo 2^XLEN.
  - AND/OR/XOR: bitwise.
  - BEQ_OP: result=0, zero=(a==b).
  - Any other encoding: treated as ADD.
- `zero` is registered with `result`; it is (result==0) for all ops except BEQ_OP.
- Overflow/carry are discarded; no flags other than `zero`.
- Shift amount uses only the low `$clog2(XLEN)` bits of src_b (b=37 → shamt 5).
- Inputs are ignored whenever `in_ready`=0.
- Reset mid-operation: the in-flight op is discarded and the next cycle is IDLE.

## Timing

- Reset values: `in_ready`=1 after reset; `out_valid`=0, `result`=0, `zero`=0; state IDLE; counter 0.
- Accept at edge T.
  - Non-shift or shamt==0: `out_valid` high after edge T+1.
  - Serial shift of n>0: `out_valid` high after edge T+1+n.
  - Maximum latency: XLEN cycles (shamt=XLEN−1, so T+XLEN).
- Result handshake completes at the edge where `out_valid && out_ready`. `in_ready` rises the following cycle.
- Minimum issue interval: 2 cycles (IDLE→DONE→IDLE).
- `out_ready` held low keeps DONE indefinitely with outputs unchanged.
- `rst_n` low at any edge overrides all transitions.

## Configuration

- `ALU_FAST_SHIFT_EN` defined: shifts are computed in one cycle by a barrel shifter in IDLE. SHIFT state and counter are compiled out, and every op has a 1-cycle latency.
- Not defined: serial shifter as described; area-minimal.
- Results and `zero` must be identical in both builds; only latency differs.

## Structure

- `rv32i_pkg` supplies `alu_op_t` and its members (ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP, SLL_OP, SRL_OP, SRA_OP, BEQ_OP).
- Add constant `SHAMT_W`=5 to `rv32i_pkg`.
- State enum is local to the module.
- Sub-module `alu_comb`: combinational single-cycle ops (add/sub/logic/compare and, when `ALU_FAST_SHIFT_EN` is defined, the barrel shift). `alu_seq_exec` owns the FSM, shift register, counter and handshakes.

## Test plan

1. ADD_OP a=5 b=7, out_ready=1 → result=12, zero=0, `out_valid` 1 cycle after accept.
2. SUB_OP a=9 b=9 → result=0, zero=1.
3. BEQ_OP a=b=0xDEADBEEF → result=0, zero=1. Then a=0xDEADBEEF b=0xDEADBEEE → result=0, zero=0.
4. Serial shifts:
   - SRA_OP a=0x80000000 b=4 → 0xF8000000 after 5 cycles.
   - SRL_OP same operands → 0x08000000.
   - SLL_OP a=1 b=37 → 0x00000020 after 6 cycles.
   - SLL_OP b=0 → a after 1 cycle.
5. Backpressure: out_ready=0 for 3 cycles after `out_valid` → result/zero stable, `in_ready`=0, and a new in_valid is ignored. Raising out_ready → `in_ready`=1 next cycle.
6. Reset during SHIFT (SLL_OP b=20, rst_n low at cycle 3) → next cycle `out_valid`=0, result=0, `in_ready`=1. A subsequent ADD 1+1 → 2.
